// File: rtl/load_store_unit_if.sv
// Bus bundle between the CPU execute stage, the load/store unit and the data
// memory.
//   req_*   : request handshake from the CPU (valid/ready)
//   resp_*  : single-cycle completion pulse back to the CPU
//   mem_*   : data-memory strobes; mem_rdata is valid one cycle after mem_read
// Modports:
//   slave  : the load/store unit. It accepts requests and drives the memory.
//   master : the CPU and memory side, for example a testbench.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addrs;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_read, mem_write, mem_addrs, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_read, mem_write, mem_addrs, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: the initiator side of the data-memory interface.
// It takes one load or store at a time and drives the data memory, which has a
// 1-cycle registered read latency. Sub-word stores are done as read-modify-write.
// It returns a one-cycle response pulse that carries load data or an error flag.
// Ports:
//   clk   : rising-edge clock, shared with the data memory
//   rst_n : asynchronous active-low reset
//   bus   : load_store_unit_if.slave (request, response and memory signals)
// Parameter:
//   DEPTH_LOG2 : log2 of the memory depth in 32-bit words
module load_store_unit #(
    parameter int DEPTH_LOG2 = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_WR, ERR} state_t;

    localparam logic [32:0] MEM_WORDS = 33'd1 << DEPTH_LOG2;

    state_t      state;
    logic        we_q, sgn_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic        resp_valid_q, resp_err_q;
    logic [31:0] resp_rdata_q;

    logic        req_bad;
    logic [4:0]  bsh, hsh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_ext, merged, mask;

    // Legality is judged on the live request, so a bad request never reaches memory.
    always_comb begin
        req_bad = 1'b0;
        case (bus.req_size)
            2'b01:   req_bad = bus.req_addr[0];
            2'b10:   req_bad = |bus.req_addr[1:0];
            2'b11:   req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
        if ({3'b000, bus.req_addr[31:2]} >= MEM_WORDS) req_bad = 1'b1;
    end

    // Lane extraction for loads and lane merge for sub-word stores. Lanes are
    // little-endian.
    always_comb begin
        bsh    = {addr_q[1:0], 3'b000};
        hsh    = {addr_q[1], 4'b0000};
        lane_b = 8'(bus.mem_rdata >> bsh);
        lane_h = 16'(bus.mem_rdata >> hsh);
        case (size_q)
            2'b00:   ld_ext = {{24{sgn_q & lane_b[7]}}, lane_b};
            2'b01:   ld_ext = {{16{sgn_q & lane_h[15]}}, lane_h};
            default: ld_ext = bus.mem_rdata;
        endcase
        if (size_q == 2'b00) begin
            mask   = 32'h0000_00FF << bsh;
            merged = (bus.mem_rdata & ~mask) | ((32'(wdata_q[7:0]) << bsh) & mask);
        end else begin
            mask   = 32'h0000_FFFF << hsh;
            merged = (bus.mem_rdata & ~mask) | ((32'(wdata_q[15:0]) << hsh) & mask);
        end
    end

    // The strobes decode from the state register only. An asynchronous reset
    // therefore removes them at once, and no partial write can occur.
    assign bus.req_ready  = (state == IDLE);
    assign bus.mem_read   = (state == RD) || (state == RMW_RD);
    assign bus.mem_write  = (state == WR) || (state == RMW_WR);
    assign bus.mem_addrs  = {2'b00, addr_q[31:2]};
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;

    always_comb begin
        case (state)
            WR:      bus.mem_wdata = wdata_q;
            RMW_WR:  bus.mem_wdata = merged;
            default: bus.mem_wdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            sgn_q        <= 1'b0;
            size_q       <= 2'b00;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: if (bus.req_valid) begin
                    we_q    <= bus.req_we;
                    sgn_q   <= bus.req_signed;
                    size_q  <= bus.req_size;
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                    if (req_bad) begin
                        // The error response is issued directly. ERR only
                        // blocks acceptance for that one cycle.
                        state        <= ERR;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= 32'h0;
                    end else if (!bus.req_we)        state <= RD;
                    else if (bus.req_size == 2'b10)  state <= WR;
                    else                             state <= RMW_RD;
                end
                RD:      state <= RD_WAIT;
                RMW_RD:  state <= RMW_WR;
                RD_WAIT: begin
                    state        <= IDLE;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= ld_ext;
                end
                WR, RMW_WR: begin
                    state        <= IDLE;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    load_store_unit_if bus();

    load_store_unit #(.DEPTH_LOG2(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Data memory model: 1-cycle registered read; reads take priority over writes.
    logic [31:0] mem [0:255];
    logic [31:0] rdata_q = 32'h0;
    always @(posedge clk) begin
        if (bus.mem_read)       rdata_q <= mem[bus.mem_addrs[7:0]];
        else if (bus.mem_write) mem[bus.mem_addrs[7:0]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = rdata_q;

    // The read and write strobes must never be high together.
    always @(negedge clk) begin
        checks++;
        if (bus.mem_read && bus.mem_write) begin
            errors++;
            $display("FAIL strobe_overlap read=%b write=%b, want not both 1", bus.mem_read, bus.mem_write);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Call at a negedge while the unit is in IDLE. Returns at the negedge of C1.
    task automatic drive_req(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_signed = sgn; bus.req_addr = addr; bus.req_wdata = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Returns at the negedge of the response cycle (C3).
    task automatic run_load(input logic [1:0] size, input logic sgn, input logic [31:0] addr);
        drive_req(1'b0, size, sgn, addr, 32'h0);
        repeat (2) @(negedge clk);
    endtask

    // Returns at the negedge of the response cycle (C2 for a word, C3 for a sub-word).
    task automatic run_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        drive_req(1'b1, size, 1'b0, addr, wdata);
        if (size != 2'b10) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp got v=%b e=%b want 0/0", bus.resp_valid, bus.resp_err); end
        checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", bus.resp_rdata); end
        checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL rst_strobes got r=%b w=%b want 0/0", bus.mem_read, bus.mem_write); end
        checks++; if (bus.mem_addrs !== 32'h0) begin errors++; $display("FAIL rst_addrs got %h want 0", bus.mem_addrs); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_store_load();
        drive_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL wst_c1_strobes got w=%b r=%b want 1/0", bus.mem_write, bus.mem_read); end
        checks++; if (bus.mem_addrs !== 32'h10) begin errors++; $display("FAIL wst_addrs got %h want 00000010", bus.mem_addrs); end
        checks++; if (bus.mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wst_wdata got %h want deadbeef", bus.mem_wdata); end
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL wst_busy got %b want 0", bus.req_ready); end
        @(negedge clk);
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL wst_c2_resp got v=%b e=%b w=%b want 1/0/0", bus.resp_valid, bus.resp_err, bus.mem_write); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL wst_wdata_idle got %h want 0", bus.mem_wdata); end
        drive_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addrs !== 32'h10) begin errors++; $display("FAIL wld_c1 got r=%b w=%b a=%h want 1/0/10", bus.mem_read, bus.mem_write, bus.mem_addrs); end
        @(negedge clk);
        checks++; if (bus.resp_valid !== 1'b0 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL wld_c2 got v=%b r=%b want 0/0", bus.resp_valid, bus.mem_read); end
        @(negedge clk);
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hDEADBEEF || bus.resp_err !== 1'b0) begin errors++; $display("FAIL wld_c3 got v=%b d=%h e=%b want 1/deadbeef/0", bus.resp_valid, bus.resp_rdata, bus.resp_err); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL wld_c3_ready got %b want 1", bus.req_ready); end
        @(negedge clk);
        checks++; if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wld_hold got v=%b d=%h want 0/deadbeef", bus.resp_valid, bus.resp_rdata); end
    endtask

    task automatic test_rmw_store();
        run_store(2'b10, 32'h80, 32'h11223344);
        drive_req(1'b1, 2'b00, 1'b0, 32'h81, 32'h000000AA);
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addrs !== 32'h20) begin errors++; $display("FAIL rmw_c1 got r=%b w=%b a=%h want 1/0/20", bus.mem_read, bus.mem_write, bus.mem_addrs); end
        @(negedge clk);
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL rmw_c2 got w=%b r=%b want 1/0", bus.mem_write, bus.mem_read); end
        checks++; if (bus.mem_wdata !== 32'h1122AA44) begin errors++; $display("FAIL rmw_merge got %h want 1122aa44", bus.mem_wdata); end
        @(negedge clk);
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL rmw_c3 got v=%b e=%b d=%h want 1/0/0", bus.resp_valid, bus.resp_err, bus.resp_rdata); end
        checks++; if (mem[8'h20] !== 32'h1122AA44) begin errors++; $display("FAIL rmw_mem got %h want 1122aa44", mem[8'h20]); end
        @(negedge clk);
        run_store(2'b01, 32'h82, 32'h0000BEEF);
        checks++; if (mem[8'h20] !== 32'hBEEFAA44) begin errors++; $display("FAIL rmw_half_mem got %h want beefaa44", mem[8'h20]); end
    endtask

    task automatic test_load_ext();
        logic [1:0]  sz  [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
        logic        sg  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ad  [5] = '{32'h100, 32'h100, 32'h100, 32'h102, 32'h101};
        logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFF080, 32'h00000000, 32'h000000F0};
        run_store(2'b10, 32'h100, 32'h0000F080);
        for (int i = 0; i < 5; i++) begin
            run_load(sz[i], sg[i], ad[i]);
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.resp_rdata !== exp[i]) begin
                errors++; $display("FAIL ld_ext[%0d] got v=%b e=%b d=%h want 1/0/%h", i, bus.resp_valid, bus.resp_err, bus.resp_rdata, exp[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_errors();
        logic        we [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  sz [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
        logic [31:0] ad [4] = '{32'h41, 32'h42, 32'h40, 32'h40000};
        for (int i = 0; i < 4; i++) begin
            drive_req(we[i], sz[i], 1'b0, ad[i], 32'h12345678);
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 32'h0) begin
                errors++; $display("FAIL err_resp[%0d] got v=%b e=%b d=%h want 1/1/0", i, bus.resp_valid, bus.resp_err, bus.resp_rdata);
            end
            checks++;
            if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
                errors++; $display("FAIL err_strobes[%0d] got r=%b w=%b want 0/0", i, bus.mem_read, bus.mem_write);
            end
            @(negedge clk);
            checks++;
            if (bus.resp_valid !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.req_ready !== 1'b1) begin
                errors++; $display("FAIL err_after[%0d] got v=%b r=%b w=%b rdy=%b want 0/0/0/1", i, bus.resp_valid, bus.mem_read, bus.mem_write, bus.req_ready);
            end
        end
        checks++; if (mem[8'h10] !== 32'hDEADBEEF) begin errors++; $display("FAIL err_mem_untouched got %h want deadbeef", mem[8'h10]); end
        // Word index 65535 is the last one in range.
        run_load(2'b10, 1'b0, 32'h3FFFC);
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL err_top_index got v=%b e=%b want 1/0", bus.resp_valid, bus.resp_err); end
        @(negedge clk);
    endtask

    task automatic test_reset_rmw();
        run_store(2'b10, 32'h80, 32'h11223344);
        drive_req(1'b1, 2'b00, 1'b0, 32'h81, 32'h00000055);
        @(negedge clk);
        checks++; if (bus.mem_write !== 1'b1) begin errors++; $display("FAIL rst_rmw_pre got w=%b want 1", bus.mem_write); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL rst_rmw_drop got w=%b r=%b want 0/0", bus.mem_write, bus.mem_read); end
        @(negedge clk);
        checks++; if (mem[8'h20] !== 32'h11223344) begin errors++; $display("FAIL rst_rmw_mem got %h want 11223344", mem[8'h20]); end
        checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_rmw_state got v=%b rdy=%b want 0/1", bus.resp_valid, bus.req_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.resp_valid !== 1'b0 || mem[8'h20] !== 32'h11223344) begin errors++; $display("FAIL rst_rmw_after got v=%b m=%h want 0/11223344", bus.resp_valid, mem[8'h20]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ad  [3] = '{32'h40, 32'h80, 32'h100};
        logic [31:0] exp [3] = '{32'hDEADBEEF, 32'h11223344, 32'h0000F080};
        int acc_cyc [3];
        int rsp_cyc [3];
        int n_acc = 0;
        int n_rsp = 0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
        bus.req_signed = 1'b0; bus.req_addr = ad[0]; bus.req_wdata = 32'h0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (bus.resp_valid) begin
                if (n_rsp < 3) begin
                    rsp_cyc[n_rsp] = cyc;
                    checks++;
                    if (bus.resp_rdata !== exp[n_rsp] || bus.resp_err !== 1'b0) begin
                        errors++; $display("FAIL b2b_data[%0d] got d=%h e=%b want %h/0", n_rsp, bus.resp_rdata, bus.resp_err, exp[n_rsp]);
                    end
                end
                n_rsp++;
            end
            if (bus.req_valid && bus.req_ready) begin
                if (n_acc < 3) acc_cyc[n_acc] = cyc;
                n_acc++;
                @(posedge clk); #1;
                if (n_acc < 3) bus.req_addr = ad[n_acc];
                else           bus.req_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (n_acc != 3 || n_rsp != 3) begin errors++; $display("FAIL b2b_count got acc=%0d rsp=%0d want 3/3", n_acc, n_rsp); end
        for (int i = 0; i < 3; i++) begin
            if (i < n_acc) begin
                checks++; if (acc_cyc[i] != 3 * i) begin errors++; $display("FAIL b2b_accept[%0d] got cycle %0d want %0d", i, acc_cyc[i], 3 * i); end
            end
            if (i < n_rsp) begin
                checks++; if (rsp_cyc[i] != 3 * i + 3) begin errors++; $display("FAIL b2b_resp[%0d] got cycle %0d want %0d", i, rsp_cyc[i], 3 * i + 3); end
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        test_reset();
        test_word_store_load();
        test_rmw_store();
        test_load_ext();
        test_errors();
        test_reset_rmw();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
